fft8_seq_core: RTL



---
 rtl/fft8_seq_core.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fft8_seq_core.sv
// Sequential 8-point radix-2 DIT FFT: one shared butterfly walks three stages over an
// in-place register file loaded in bit-reversed order and read out in natural order.
module fft8_seq_core #(
  parameter int unsigned W     = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned SCALE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_real,
  input  logic [W-1:0] in_imag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_real,
  output logic [W-1:0] out_imag,
  output logic [2:0]   out_index,
  output logic         out_last,
  output logic         busy,
  output logic         overflow
);

  localparam int PW = W + CW + 2;
  localparam int C  = $rtoi(0.70710678 * (2.0 ** (CW - 1)) + 0.5);
  localparam logic signed [PW-1:0] Coef = PW'(C);
  localparam logic signed [PW-1:0] Rnd  = PW'(2 ** (CW - 2));

  typedef enum logic [1:0] {StLoad, StCompute, StUnload} state_e;

  state_e       state;
  logic [2:0]   cnt;
  logic [1:0]   stage, bfly;
  logic [W-1:0] mem_re [8];
  logic [W-1:0] mem_im [8];

  // Rounded multiply by cos(pi/4); the result always fits in W+1 bits.
  function automatic logic signed [W:0] rmul(input logic signed [W:0] v);
    logic signed [PW-1:0] p;
    p = PW'(v) * Coef + Rnd;
    return (W + 1)'(p >>> (CW - 1));
  endfunction

  // Returns {saturated, value}.
  function automatic logic [W:0] sat(input logic signed [W+1:0] v);
    logic signed [W+1:0] s;
    s = (SCALE != 0) ? (v >>> 1) : v;
    if (s[W+1:W-1] == 3'b000 || s[W+1:W-1] == 3'b111) return {1'b0, s[W-1:0]};
    else if (s[W+1]) return {1'b1, 1'b1, {(W - 1){1'b0}}};
    else return {1'b1, 1'b0, {(W - 1){1'b1}}};
  endfunction

  logic [2:0]          a_idx, b_idx;
  logic [1:0]          tw;
  logic signed [W+1:0] ar, ai;
  logic signed [W:0]   br, bi, bsum, bdif, tr, ti;
  logic [W:0]          ur, ui, lr, li;

  always_comb begin
    a_idx = 3'd0;
    b_idx = 3'd0;
    tw    = 2'd0;
    case (stage)
      2'd0: begin
        a_idx = {bfly, 1'b0};
        b_idx = {bfly, 1'b1};
      end
      2'd1: begin
        a_idx = {bfly[1], 1'b0, bfly[0]};
        b_idx = {bfly[1], 1'b1, bfly[0]};
        tw    = {bfly[0], 1'b0};
      end
      default: begin
        a_idx = {1'b0, bfly};
        b_idx = {1'b1, bfly};
        tw    = bfly;
      end
    endcase
  end

  always_comb begin
    ar   = (W + 2)'($signed(mem_re[a_idx]));
    ai   = (W + 2)'($signed(mem_im[a_idx]));
    br   = (W + 1)'($signed(mem_re[b_idx]));
    bi   = (W + 1)'($signed(mem_im[b_idx]));
    bsum = br + bi;
    bdif = bi - br;
    tr   = br;
    ti   = bi;
    case (tw)
      2'd0: begin
        tr = br;
        ti = bi;
      end
      2'd1: begin
        tr = rmul(bsum);
        ti = rmul(bdif);
      end
      2'd2: begin
        tr = bi;
        ti = -br;
      end
      default: begin
        tr = rmul(bdif);
        ti = -rmul(bsum);
      end
    endcase
    ur = sat(ar + (W + 2)'(tr));
    ui = sat(ai + (W + 2)'(ti));
    lr = sat(ar - (W + 2)'(tr));
    li = sat(ai - (W + 2)'(ti));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StLoad;
      cnt      <= 3'd0;
      stage    <= 2'd0;
      bfly     <= 2'd0;
      overflow <= 1'b0;
    end else begin
      case (state)
        StLoad: begin
          if (in_valid) begin
            mem_re[{cnt[0], cnt[1], cnt[2]}] <= in_real;
            mem_im[{cnt[0], cnt[1], cnt[2]}] <= in_imag;
            if (cnt == 3'd0) overflow <= 1'b0;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= StCompute;
          end
        end
        StCompute: begin
          mem_re[a_idx] <= ur[W-1:0];
          mem_im[a_idx] <= ui[W-1:0];
          mem_re[b_idx] <= lr[W-1:0];
          mem_im[b_idx] <= li[W-1:0];
          overflow      <= overflow | ur[W] | ui[W] | lr[W] | li[W];
          bfly          <= bfly + 2'd1;
          if (bfly == 2'd3) begin
            if (stage == 2'd2) begin
              stage <= 2'd0;
              state <= StUnload;
            end else begin
              stage <= stage + 2'd1;
            end
          end
        end
        StUnload: begin
          if (out_ready) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= StLoad;
          end
        end
        default: state <= StLoad;
      endcase
    end
  end

  assign in_ready  = (state == StLoad);
  assign busy      = (state == StCompute);
  assign out_valid = (state == StUnload);
  assign out_index = out_valid ? cnt : 3'd0;
  assign out_last  = out_valid && (cnt == 3'd7);
  assign out_real  = mem_re[cnt];
  assign out_imag  = mem_im[cnt];

endmodule
